credit_token_tx: RTL and testbench

- Transmit-side credit tracker for a remote dataless, counter-only token FIFO (depth p1depth) on the far end of a link.
- Local producer enqueues tokens against a credit pool; accepted tokens leave as single-cycle pulses; the remote side returns credits in batches as it dequeues.
- Owns the four-phase remote-clear handshake; credits are restored only after the remote confirms it is empty.

---
 rtl/credit_link_pkg.sv | 25 ++
 rtl/clr_4ph_initiator.sv | 42 ++++
 rtl/credit_token_tx.sv | 94 +++++++++
 tb/tb_credit_token_tx.sv | 123 ++++++++++++
 4 files changed

// File: rtl/credit_link_pkg.sv
// Definitions shared by both ends of the credit link: clear-handshake state
// encoding, credit-width helper and the control-signal bundle.
package credit_link_pkg;

  localparam logic [1:0] ST_RUN  = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

  // Smallest n with 2**n >= value; credit width is clog2(depth + 1).
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

  // Single-bit link wires; RET_CNT is sized per instance and travels alongside.
  typedef struct packed {
    logic tok;
    logic ret_valid;
    logic rclr_req;
    logic rclr_ack;
  } credit_link_ctl_t;

endpackage

// File: rtl/clr_4ph_initiator.sv
// Initiator side of the four-phase remote clear: raise req, wait for ack,
// drop req, wait for ack to fall, then pulse done for one cycle.
module clr_4ph_initiator
  import credit_link_pkg::*;
(
  input  logic CLK,
  input  logic RST_N,
  input  logic start_i,
  input  logic ack_i,
  output logic busy_o,
  output logic req_o,
  output logic done_o
);

  logic [1:0] state_q;
  logic [1:0] state_d;

  always_comb begin
    state_d = state_q;
    done_o  = 1'b0;
    case (state_q)
      ST_RUN:  if (start_i) state_d = ST_REQ;
      ST_REQ:  if (ack_i) state_d = ST_DROP;
      ST_DROP: begin
        if (!ack_i) begin
          state_d = ST_RUN;
          done_o  = 1'b1;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

  assign req_o  = (state_q == ST_REQ);
  assign busy_o = (state_q != ST_RUN);

endmodule

// File: rtl/credit_token_tx.sv
// Transmit-side credit tracker for a remote counter-only token FIFO: spends a
// credit per accepted token, absorbs returned credits, and restores on clear.
module credit_token_tx
  import credit_link_pkg::*;
#(
  parameter int p1depth      = 2,
  parameter int p2cntr_width = clog2(p1depth + 1),
  parameter bit guarded      = 1'b1
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    ENQ,
  output logic                    FULL_N,
  input  logic                    CLR,
  output logic                    CLR_BUSY,
  output logic                    TOK_OUT,
  input  logic                    RET_VALID,
  input  logic [p2cntr_width-1:0] RET_CNT,
  output logic                    RCLR_REQ,
  input  logic                    RCLR_ACK,
  output logic [p2cntr_width-1:0] CREDITS,
  output logic                    OVF_ERR
);

  localparam int W = p2cntr_width;
  localparam logic [W-1:0] DEPTH_W = W'(p1depth);
  localparam logic [W:0]   DEPTH_X = (W+1)'(p1depth);

  logic [W-1:0] credits_q, credits_d;
  logic         tok_q;
  logic         ovf_q, ovf_d;
  logic         busy, clr_done, clr_start, acc;
  logic [W:0]   ret_x, sum;

  clr_4ph_initiator u_clr (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .start_i (clr_start),
    .ack_i   (RCLR_ACK),
    .busy_o  (busy),
    .req_o   (RCLR_REQ),
    .done_o  (clr_done)
  );

  assign FULL_N    = !busy && (credits_q != '0);
  assign clr_start = CLR && !busy;
  // A clear request wins over an enqueue in the same cycle.
  assign acc       = ENQ && FULL_N && !CLR;

  assign ret_x = RET_VALID ? {1'b0, RET_CNT} : '0;
  assign sum   = {1'b0, credits_q} - {{W{1'b0}}, acc} + ret_x;

  always_comb begin
    credits_d = credits_q;
    ovf_d     = ovf_q;
    if (clr_done) begin
      credits_d = DEPTH_W;
    end else if (!busy) begin
      if (sum > DEPTH_X) begin
        credits_d = DEPTH_W;
        ovf_d     = 1'b1;
      end else begin
        credits_d = sum[W-1:0];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      credits_q <= DEPTH_W;
      tok_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      credits_q <= credits_d;
      tok_q     <= acc;
      ovf_q     <= ovf_d;
    end
  end

  generate
    if (guarded) begin : g_guard
      always_ff @(posedge CLK) begin
        if (RST_N && ENQ && !FULL_N)
          $warning("credit_token_tx: ENQ while FULL_N low is ignored");
      end
    end
  endgenerate

  assign CLR_BUSY = busy;
  assign TOK_OUT  = tok_q;
  assign CREDITS  = credits_q;
  assign OVF_ERR  = ovf_q;

endmodule

// File: tb/tb_credit_token_tx.sv
// Directed bench for credit_token_tx (depth 4): each step pushes the expected
// post-edge outputs to a scoreboard, then pops and checks them after the edge.
module tb_credit_token_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enq = 1'b0, clr = 1'b0, ret_valid = 1'b0, rclr_ack = 1'b0;
  logic [2:0] ret_cnt = 3'd0;
  logic       full_n, clr_busy, tok_out, rclr_req, ovf_err;
  logic [2:0] credits;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string      tag;
    logic       tok;
    logic [2:0] cred;
    logic       full;
    logic       busy;
    logic       rreq;
    logic       ovf;
  } exp_t;

  exp_t sb[$];

  credit_token_tx #(.p1depth(4), .p2cntr_width(3), .guarded(1'b0)) dut (
    .CLK       (clk),
    .RST_N     (rst_n),
    .ENQ       (enq),
    .FULL_N    (full_n),
    .CLR       (clr),
    .CLR_BUSY  (clr_busy),
    .TOK_OUT   (tok_out),
    .RET_VALID (ret_valid),
    .RET_CNT   (ret_cnt),
    .RCLR_REQ  (rclr_req),
    .RCLR_ACK  (rclr_ack),
    .CREDITS   (credits),
    .OVF_ERR   (ovf_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input string field, input logic [2:0] obs, input logic [2:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s.%s observed=%0d expected=%0d", tag, field, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, record the expected result, clock it, then check.
  task automatic step(input string tag, input logic rst_n_v, input logic enq_v,
                      input logic clr_v, input logic rv_v, input logic [2:0] rc_v,
                      input logic ack_v, input logic e_tok, input logic [2:0] e_cred,
                      input logic e_full, input logic e_busy, input logic e_rreq,
                      input logic e_ovf);
    exp_t e, got;
    rst_n = rst_n_v; enq = enq_v; clr = clr_v;
    ret_valid = rv_v; ret_cnt = rc_v; rclr_ack = ack_v;
    e.tag = tag; e.tok = e_tok; e.cred = e_cred; e.full = e_full;
    e.busy = e_busy; e.rreq = e_rreq; e.ovf = e_ovf;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    chk(got.tag, "TOK_OUT",  {2'b0, tok_out},  {2'b0, got.tok});
    chk(got.tag, "CREDITS",  credits,          got.cred);
    chk(got.tag, "FULL_N",   {2'b0, full_n},   {2'b0, got.full});
    chk(got.tag, "CLR_BUSY", {2'b0, clr_busy}, {2'b0, got.busy});
    chk(got.tag, "RCLR_REQ", {2'b0, rclr_req}, {2'b0, got.rreq});
    chk(got.tag, "OVF_ERR",  {2'b0, ovf_err},  {2'b0, got.ovf});
    $display("step %-10s tok=%0d cred=%0d full_n=%0d busy=%0d rreq=%0d ovf=%0d",
             tag, tok_out, credits, full_n, clr_busy, rclr_req, ovf_err);
  endtask

  initial begin
    @(negedge clk);
    //            tag          rst enq clr rv cnt ack | tok cred full busy rreq ovf
    step("reset",      0, 0, 0, 0, 3'd0, 0,   0, 3'd4, 1, 0, 0, 0);
    // ENQ held for six cycles with no returns
    step("enq1",       1, 1, 0, 0, 3'd0, 0,   1, 3'd3, 1, 0, 0, 0);
    step("enq2",       1, 1, 0, 0, 3'd0, 0,   1, 3'd2, 1, 0, 0, 0);
    step("enq3",       1, 1, 0, 0, 3'd0, 0,   1, 3'd1, 1, 0, 0, 0);
    step("enq4",       1, 1, 0, 0, 3'd0, 0,   1, 3'd0, 0, 0, 0, 0);
    step("enq5",       1, 1, 0, 0, 3'd0, 0,   0, 3'd0, 0, 0, 0, 0);
    step("enq6",       1, 1, 0, 0, 3'd0, 0,   0, 3'd0, 0, 0, 0, 0);
    // Empty pool: return plus ENQ -> no accept this cycle
    step("ret_empty",  1, 1, 0, 1, 3'd2, 0,   0, 3'd2, 1, 0, 0, 0);
    step("acc_after",  1, 1, 0, 0, 3'd0, 0,   1, 3'd1, 1, 0, 0, 0);
    // Accept and return together at one credit
    step("acc_ret",    1, 1, 0, 1, 3'd1, 0,   1, 3'd1, 1, 0, 0, 0);
    // Overflow saturation
    step("ret2",       1, 0, 0, 1, 3'd2, 0,   0, 3'd3, 1, 0, 0, 0);
    step("ovf",        1, 0, 0, 1, 3'd3, 0,   0, 3'd4, 1, 0, 0, 1);
    step("drain1",     1, 1, 0, 0, 3'd0, 0,   1, 3'd3, 1, 0, 0, 1);
    step("drain2",     1, 1, 0, 0, 3'd0, 0,   1, 3'd2, 1, 0, 0, 1);
    step("drain3",     1, 1, 0, 0, 3'd0, 0,   1, 3'd1, 1, 0, 0, 1);
    // Clear handshake with ENQ and returns during it
    step("clr",        1, 1, 1, 0, 3'd0, 0,   0, 3'd1, 0, 1, 1, 1);
    step("req_w1",     1, 1, 0, 1, 3'd2, 0,   0, 3'd1, 0, 1, 1, 1);
    step("req_w2",     1, 0, 0, 0, 3'd0, 0,   0, 3'd1, 0, 1, 1, 1);
    step("ack_hi",     1, 0, 0, 0, 3'd0, 1,   0, 3'd1, 0, 1, 0, 1);
    step("drop_ret",   1, 1, 1, 1, 3'd3, 1,   0, 3'd1, 0, 1, 0, 1);
    step("ack_lo",     1, 0, 0, 0, 3'd0, 0,   0, 3'd4, 1, 0, 0, 1);
    step("post_clr",   1, 1, 0, 0, 3'd0, 0,   1, 3'd3, 1, 0, 0, 1);
    // Reset in the middle of a handshake
    step("clr2",       1, 0, 1, 0, 3'd0, 0,   0, 3'd3, 0, 1, 1, 1);
    step("rst_req",    0, 1, 0, 0, 3'd0, 0,   0, 3'd4, 1, 0, 0, 0);
    step("post_rst",   1, 1, 0, 0, 3'd0, 0,   1, 3'd3, 1, 0, 0, 0);

    n_checks++;
    assert (sb.size() == 0) else begin
      n_fail++;
      $error("FAIL scoreboard_empty observed=%0d expected=0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
